// File: rtl/divu_seq_pkg.sv
// rtl/divu_seq_pkg.sv - shared constants and FSM state encoding for the unsigned divider
package divu_seq_pkg;

    localparam int DIVU_WIDTH = 32;
    localparam int DIVU_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } divu_state_t;

endpackage

// File: rtl/divu_step.sv
// rtl/divu_step.sv - one radix-2 restoring division iteration (combinational)
module divu_step
    import divu_seq_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic             w_unused_rem_msb;

    // The partial remainder after k iterations holds at most k dividend bits, so
    // its MSB is always 0 before a shift and can be dropped from the trial.
    assign w_unused_rem_msb = i_rem[WIDTH-1];

    // Shift the next dividend bit in, trial-subtract, restore on borrow.
    always_comb begin
        w_shift  = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
        w_trial  = {1'b0, w_shift} - {1'b0, i_divisor};
        w_borrow = w_trial[WIDTH];
        o_rem    = w_borrow ? w_shift : w_trial[WIDTH-1:0];
        o_quo    = {i_quo[WIDTH-2:0], ~w_borrow};
    end

endmodule

// File: rtl/divu_seq.sv
// rtl/divu_seq.sv - unsigned sequential restoring divider with start/busy/done handshake
module divu_seq
    import divu_seq_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    divu_state_t      r_state;
    divu_state_t      w_next_state;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    divu_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    // Next-state and handshake decode; a new divide may start from IDLE or DONE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset aborts any divide in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture, one iteration per RUN cycle, results latched on the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_dz      <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= dividend;
            r_divisor <= divisor;
        end else if (r_state == S_RUN) begin
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_q  <= w_quo_nx;
                r_r  <= w_rem_nx;
                r_dz <= (r_divisor == '0);
            end
        end
    end

    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dz;

endmodule
